// File: rtl/mac_pkg.sv
// Shared types and default widths for the multiply-accumulate back end.
package mac_pkg;

    localparam int MAC_PW = 16;   // product width, matches the multiplier output
    localparam int MAC_AW = 20;   // accumulator / sum width
    localparam int MAC_LW = 8;    // job length field width

    // Saturation value of a default-width accumulator.
    localparam logic [MAC_AW-1:0] SAT_MAX = {MAC_AW{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mac_state_t;

endpackage

// File: rtl/sat_add.sv
// Combinational saturating adder: AW-bit accumulator plus a zero-extended
// PW-bit unsigned operand, clamped to all-ones when the carry out is set.
import mac_pkg::*;

module sat_add #(
    parameter int PW = MAC_PW,
    parameter int AW = MAC_AW
) (
    input  logic [AW-1:0] a,
    input  logic [PW-1:0] b,
    output logic [AW-1:0] y,
    output logic          ovf
);

    logic [AW:0] sum;

    // One extra bit catches the carry; a saturated input plus any non-zero
    // operand carries again, so saturation is self-sustaining.
    always_comb begin
        sum = {1'b0, a} + (AW+1)'(b);
        ovf = sum[AW];
        y   = ovf ? {AW{1'b1}} : sum[AW-1:0];
    end

endmodule

// File: rtl/mac_accum.sv
// Multiply-accumulate back end: accepts a programmed number of products over
// a valid/ready handshake, registers each one, sums them into a saturating
// accumulator and offers the result over an output valid/ready handshake.
import mac_pkg::*;

module mac_accum #(
    parameter int PW = MAC_PW,
    parameter int AW = MAC_AW,
    parameter int LW = MAC_LW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_start,
    input  logic [LW-1:0] i_len,
    input  logic [PW-1:0] i_prod,
    input  logic          i_valid,
    output logic          o_ready,
    output logic [AW-1:0] o_sum,
    output logic          o_valid,
    input  logic          i_ready,
    output logic          o_ovf,
    output logic          o_busy
);

    mac_state_t    state, state_nxt;
    logic [LW-1:0] remaining;
    logic [PW-1:0] p_reg;
    logic          p_vld;
    logic [AW-1:0] acc;
    logic [AW-1:0] acc_add;
    logic          add_ovf;
    logic          ovf;
    logic          xfer;

    sat_add #(.PW(PW), .AW(AW)) u_sat_add (
        .a   (acc),
        .b   (p_reg),
        .y   (acc_add),
        .ovf (add_ovf)
    );

    assign xfer   = i_valid & o_ready;
    assign o_busy = (state != IDLE);
    assign o_sum  = acc;
    assign o_ovf  = ovf;

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        o_ready   = 1'b0;
        o_valid   = 1'b0;
        case (state)
            IDLE: begin
                if (i_start)
                    state_nxt = (i_len == '0) ? DONE : ACCUM;
            end
            ACCUM: begin
                o_ready = 1'b1;
                if (i_valid && remaining == LW'(1))
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                state_nxt = DONE;
            end
            DONE: begin
                o_valid = 1'b1;
                // A start seen together with i_ready is deliberately dropped.
                if (i_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Product register, length counter and accumulator; each accepted
    // product is summed on the edge after it was registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            remaining <= '0;
            p_reg     <= '0;
            p_vld     <= 1'b0;
            acc       <= '0;
            ovf       <= 1'b0;
        end else if (state == IDLE && i_start) begin
            remaining <= i_len;
            p_vld     <= 1'b0;
            acc       <= '0;
            ovf       <= 1'b0;
        end else begin
            if (p_vld) begin
                acc <= acc_add;
                if (add_ovf)
                    ovf <= 1'b1;
            end
            p_vld <= xfer;
            if (xfer) begin
                p_reg     <= i_prod;
                remaining <= remaining - LW'(1);
            end
        end
    end

endmodule

// File: doc/mac_accum.md
Name: mac_accum

Overview:
- Sequential multiply-accumulate back end that sits directly downstream of the 8x8 combinational multiplier (mult / mult_lzh).
- Consumes the 16-bit unsigned product stream via a valid/ready handshake, registers each product, and sums a programmed number of products into a saturating accumulator.
- Presents the final sum through an output valid/ready handshake.
- Used for dot-product style computations in the lab datapath.

Parameters:
- PW, 16, product width; matches multiplier `out`.
- AW, 20, accumulator/sum width; must be >= PW.
- LW, 8, width of the length field (max 2^LW-1 products per job).

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- i_start  input  1  start pulse; sampled only in IDLE.
- i_len  input  LW  number of products to accumulate; sampled with i_start.
- i_prod  input  PW  unsigned product from multiplier.
- i_valid  input  1  i_prod valid.
- o_ready  output  1  block accepts i_prod this cycle.
- o_sum  output  AW  accumulated result.
- o_valid  output  1  o_sum valid.
- i_ready  input  1  downstream accepts o_sum.
- o_ovf  output  1  sum saturated during this job.
- o_busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: clk and reset are the only clock/reset. Reset is synchronous, active-high, and overrides everything including mid-job. After the reset edge:
  - state = IDLE.
  - o_ready, o_valid, o_ovf and o_busy = 0; o_sum = 0.
  - Product register empty; count = 0.
- States: IDLE, ACCUM, DRAIN, DONE.
- IDLE:
  - On i_start, latch i_len into `remaining`, clear the accumulator and o_ovf.
  - Go to ACCUM if i_len != 0; go directly to DONE if i_len == 0 (o_sum = 0).
- ACCUM:
  - o_ready = 1. A transfer occurs when i_valid && o_ready.
  - On a transfer, i_prod loads the product register (p_reg, p_vld = 1) and `remaining` decrements.
  - Every cycle with p_vld = 1, the accumulator adds p_reg, so each product is summed one cycle after acceptance.
  - When the transfer with remaining == 1 occurs, go to DRAIN.
  - If i_valid is low, p_vld clears and the accumulator holds.
- DRAIN:
  - o_ready = 0. Add the final p_reg, then go to DONE.
  - Last-accepted product at edge t, accumulator updated at edge t+1, o_valid high from edge t+1.
- DONE:
  - o_valid = 1; o_sum holds the accumulator.
  - On i_valid-independent i_ready = 1, go to IDLE next edge. o_valid drops; o_sum keeps its value until the next start.
- Arithmetic:
  - Unsigned. The product is zero-extended to AW+1 bits and added.
  - If bit AW is set, the accumulator saturates to 2^AW-1 and o_ovf sets (sticky until the next start).
  - Further adds on a saturated accumulator keep it saturated.
- Boundaries:
  - i_start outside IDLE is ignored; i_len is not re-sampled.
  - i_start and i_ready in the same DONE cycle: return to IDLE only; the start is not captured.
  - i_prod/i_valid while o_ready = 0 are ignored (no implicit buffering).
  - Back-to-back transfers at full rate are supported: one product per cycle.
  - Reset during ACCUM or DRAIN discards the partial sum; o_valid never pulses for an aborted job.

Decomposition:
- Package mac_pkg holds:
  - The state enum (IDLE, ACCUM, DRAIN, DONE).
  - Localparams for the default PW/AW/LW.
  - The saturation constant SAT_MAX = {AW{1'b1}}.
- One sub-module, sat_add: combinational AW-bit saturating adder with a PW-bit zero-extended operand and an overflow flag output.
- The FSM, counter and registers stay in mac_accum.

Test Plan:
- Reset then idle: no start for 10 cycles -> o_valid = 0, o_ready = 0, o_busy = 0, o_sum = 0.
- i_len = 3, products 6*7 = 42, 255*255 = 65025 and 0 at full rate -> o_valid 1 cycle after the last acceptance, o_sum = 65067, o_ovf = 0; the block holds until i_ready, then returns to IDLE.
- i_len = 17, each product 65025 (the sum reaches 1,105,425 > 2^20-1) -> o_sum = 1,048,575, o_ovf = 1.
- i_len = 0 -> DONE on the next edge, o_valid = 1, o_sum = 0; i_valid pulses in that window are not consumed.
- i_len = 4 with i_valid gaps (pattern 1,0,0,1,1,0,1) of products 1, 2, 3, 4 -> o_sum = 10; o_ready is 0 in DRAIN/DONE; i_ready held low for 5 cycles keeps o_valid and o_sum stable.
- Reset asserted mid-ACCUM after 2 of 5 products -> all outputs return to reset values. A new job with i_len = 1 and product 9 then yields o_sum = 9, with no stale contribution.
